// File: rtl/leaf_sched_pkg.sv
// ============================================================================
// Module      : leaf_sched_pkg
// Description : Shared types, default constants and helpers for the leaf
//               round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leaf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } sched_state_e;

    localparam int NUM_REQ_DEF  = 5;
    localparam int CNT_W_DEF    = 16;
    localparam int MAX_HOLD_DEF = 64;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_w(input int n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : leaf_sched_pkg

`default_nettype wire

// File: rtl/leaf_rr_pick.sv
// ============================================================================
// Module      : leaf_rr_pick
// Description : Combinational rotate-priority picker; returns the first set
//               request at or after ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leaf_rr_pick
    import leaf_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    int k;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        k     = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            k = (int'(ptr) + off) % NUM_REQ;
            if (req[k]) begin
                idx = IW'(k);
            end
        end
    end

endmodule : leaf_rr_pick

`default_nettype wire

// File: rtl/leaf_rr_scheduler.sv
// ============================================================================
// Module      : leaf_rr_scheduler
// Description : Exclusive round-robin grant of one shared resource among the
//               leaf instances of a root, with a saturating grant counter.
//               Optional forced revoke when LEAF_SCHED_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leaf_rr_scheduler
    import leaf_sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            grant_cnt,
    output logic                        timeout
);

    localparam int IW = idx_w(NUM_REQ);

    sched_state_e        state_q,    state_d;
    logic [NUM_REQ-1:0]  grant_q,    grant_d;
    logic [IW-1:0]       grant_id_q, grant_id_d;
    logic [IW-1:0]       ptr_q,      ptr_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                timeout_q,  timeout_d;

    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       ptr_next;

    leaf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pointer moves one past the current owner whenever ownership ends.
    always_comb begin
        if (grant_id_q == IW'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_id_q + 1'b1;
        end
    end

`ifdef LEAF_SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`ifdef LEAF_SCHED_TIMEOUT_EN
        hold_d     = hold_q;
`endif

        unique case (state_q)
            IDLE, RELEASE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d           = OWNED;
                    grant_d[pick_idx] = 1'b1;
                    grant_id_d        = pick_idx;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef LEAF_SCHED_TIMEOUT_EN
                    hold_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            OWNED: begin
                // A done in the same cycle as the hold limit takes priority.
                if (done[grant_id_q]) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end
`ifdef LEAF_SCHED_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    ptr_d     = ptr_next;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign busy      = |grant_q;
    assign grant_cnt = cnt_q;
`ifdef LEAF_SCHED_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;

    logic unused_timeout;
    assign unused_timeout = timeout_q;
`endif

endmodule : leaf_rr_scheduler

`default_nettype wire

// File: tb/tb_leaf_rr_scheduler.sv
// ============================================================================
// Module      : tb_leaf_rr_scheduler
// Description : Self-checking bench for leaf_rr_scheduler against a
//               behavioural ownership model; second instance with CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leaf_rr_scheduler;

    localparam int c_N = 5;
`ifdef LEAF_SCHED_TIMEOUT_EN
    localparam int c_MAX_HOLD = 4;
    localparam bit c_TO_EN    = 1'b1;
`else
    localparam int c_MAX_HOLD = 64;
    localparam bit c_TO_EN    = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [c_N-1:0] req;
    logic [c_N-1:0] done;

    logic [c_N-1:0] grant;
    logic [2:0]     grant_id;
    logic           busy;
    logic [15:0]    grant_cnt;
    logic           timeout;

    logic [c_N-1:0] s_grant;
    logic [2:0]     s_grant_id;
    logic           s_busy;
    logic [3:0]     s_cnt;
    logic           s_timeout;

    leaf_rr_scheduler #(.NUM_REQ(c_N), .CNT_W(16), .MAX_HOLD(c_MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_id(grant_id), .busy(busy),
        .grant_cnt(grant_cnt), .timeout(timeout)
    );

    leaf_rr_scheduler #(.NUM_REQ(c_N), .CNT_W(4), .MAX_HOLD(c_MAX_HOLD)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(s_grant), .grant_id(s_grant_id), .busy(s_busy),
        .grant_cnt(s_cnt), .timeout(s_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: who owns the resource, where the rotation resumes, grant totals.
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_cnt_sat;
    int m_tenure;
    bit m_timeout;

    function automatic logic [c_N-1:0] m_grant();
        logic [c_N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        m_cnt_sat = 0;
        m_tenure  = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_step(input logic [c_N-1:0] r, input logic [c_N-1:0] d);
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (d[m_owner]) begin
                m_ptr   = (m_owner + 1) % c_N;
                m_owner = -1;
            end else if (c_TO_EN && m_tenure == c_MAX_HOLD) begin
                m_ptr     = (m_owner + 1) % c_N;
                m_owner   = -1;
                m_timeout = 1'b1;
            end else begin
                m_tenure++;
            end
        end else begin
            for (int off = 0; off < c_N; off++) begin
                if (m_owner < 0 && r[(m_ptr + off) % c_N]) begin
                    m_owner   = (m_ptr + off) % c_N;
                    m_tenure  = 1;
                    m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                    m_cnt_sat = (m_cnt_sat < 15) ? m_cnt_sat + 1 : m_cnt_sat;
                end
            end
        end
    endtask

    task automatic step(input logic [c_N-1:0] r, input logic [c_N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (grant !== 5'b0) $display("FAIL reset_grant: got %b expected %b", grant, 5'b0); else n_pass++;
        n_total++; if (grant_id !== 3'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (grant_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", grant_cnt); else n_pass++;
        n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout); else n_pass++;
    endtask

    task automatic test_single_grant();
        apply_reset();
        step(5'b00100, 5'b0);
        n_total++; if (grant !== 5'b00100) $display("FAIL single_grant: got %b expected 00100", grant); else n_pass++;
        n_total++; if (grant_id !== 3'd2) $display("FAIL single_id: got %0d expected 2", grant_id); else n_pass++;
        n_total++; if (grant_cnt !== 16'd1) $display("FAIL single_cnt: got %0d expected 1", grant_cnt); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        step(5'b00000, 5'b00100);
        n_total++; if (grant !== 5'b0) $display("FAIL single_release: got %b expected 00000", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single_release_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_rotate();
        logic [c_N-1:0] exp_g;
        apply_reset();
        step(5'b11111, 5'b0);
        for (int i = 0; i < 6; i++) begin
            exp_g = '0;
            exp_g[i % c_N] = 1'b1;
            n_total++; if (grant !== exp_g) $display("FAIL rotate_order[%0d]: got %b expected %b", i, grant, exp_g); else n_pass++;
            n_total++; if (grant !== m_grant()) $display("FAIL rotate_model[%0d]: got %b expected %b", i, grant, m_grant()); else n_pass++;
            step(5'b11111, exp_g);
            n_total++; if (grant !== 5'b0) $display("FAIL rotate_gap[%0d]: got %b expected 00000", i, grant); else n_pass++;
            step(5'b11111, 5'b0);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        step(5'b00010, 5'b0);
        for (int i = 0; i < 3; i++) begin
            step(5'b00000, 5'b01000);
            n_total++; if (grant !== 5'b00010) $display("FAIL hold_keep[%0d]: got %b expected 00010", i, grant); else n_pass++;
        end
        step(5'b00000, 5'b00010);
        n_total++; if (grant !== 5'b0) $display("FAIL hold_release: got %b expected 00000", grant); else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(5'b01000, 5'b0);
        n_total++; if (grant_id !== 3'd3) $display("FAIL areset_pre_id: got %0d expected 3", grant_id); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_total++; if (grant !== 5'b0) $display("FAIL areset_grant: got %b expected 00000", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (grant_cnt !== 16'd0) $display("FAIL areset_cnt: got %0d expected 0", grant_cnt); else n_pass++;
        req  = '0;
        done = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(5'b01000, 5'b0);
        n_total++; if (grant !== 5'b01000) $display("FAIL areset_regrant: got %b expected 01000", grant); else n_pass++;
        n_total++; if (grant_id !== 3'd3) $display("FAIL areset_regrant_id: got %0d expected 3", grant_id); else n_pass++;
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step(5'b00001, 5'b0);
            n_total++; if (grant !== 5'b00001) $display("FAIL sat_grant[%0d]: got %b expected 00001", i, grant); else n_pass++;
            step(5'b00001, 5'b00001);
        end
        n_total++; if (s_cnt !== 4'd15) $display("FAIL sat_cnt4: got %0d expected 15", s_cnt); else n_pass++;
        n_total++; if (int'(s_cnt) !== m_cnt_sat) $display("FAIL sat_cnt4_model: got %0d expected %0d", s_cnt, m_cnt_sat); else n_pass++;
        n_total++; if (grant_cnt !== 16'd20) $display("FAIL sat_cnt16: got %0d expected 20", grant_cnt); else n_pass++;
    endtask

`ifdef LEAF_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        step(5'b00001, 5'b0);
        for (int i = 0; i < 3; i++) begin
            step(5'b00011, 5'b0);
            n_total++; if (grant !== 5'b00001) $display("FAIL to_hold[%0d]: got %b expected 00001", i, grant); else n_pass++;
        end
        step(5'b00011, 5'b0);
        n_total++; if (grant !== 5'b0) $display("FAIL to_revoke: got %b expected 00000", grant); else n_pass++;
        n_total++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b expected 1", timeout); else n_pass++;
        step(5'b00011, 5'b0);
        n_total++; if (grant !== 5'b00010) $display("FAIL to_next: got %b expected 00010", grant); else n_pass++;
        n_total++; if (timeout !== 1'b0) $display("FAIL to_pulse_end: got %b expected 0", timeout); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [c_N-1:0] r;
        logic [c_N-1:0] d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 4) == 0) ? 5'b0 : c_N'($urandom_range(0, 31));
            d = c_N'($urandom & $urandom & $urandom);
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) d[m_owner] = 1'b1;
            step(r, d);
            n_total++; if (grant !== m_grant()) $display("FAIL rand_grant[%0d]: got %b expected %b", i, grant, m_grant()); else n_pass++;
            n_total++; if (busy !== (m_owner >= 0)) $display("FAIL rand_busy[%0d]: got %b expected %b", i, busy, (m_owner >= 0)); else n_pass++;
            if (m_owner >= 0) begin
                n_total++; if (int'(grant_id) !== m_owner) $display("FAIL rand_id[%0d]: got %0d expected %0d", i, grant_id, m_owner); else n_pass++;
            end
            n_total++; if (int'(grant_cnt) !== m_cnt) $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, grant_cnt, m_cnt); else n_pass++;
            n_total++; if (int'(s_cnt) !== m_cnt_sat) $display("FAIL rand_cnt4[%0d]: got %0d expected %0d", i, s_cnt, m_cnt_sat); else n_pass++;
            n_total++; if (timeout !== m_timeout) $display("FAIL rand_timeout[%0d]: got %b expected %b", i, timeout, m_timeout); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_grant();
        test_rotate();
        test_hold();
        test_async_reset();
        test_saturate();
`ifdef LEAF_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_leaf_rr_scheduler

`default_nettype wire
